// File: rtl/mem_rd_req_gen.sv
// Read-request initiator: walks a descriptor ROM {type, base, offset, size,
// loop_max} and issues loop_max+1 strided reads per descriptor.
//
// Ports:
//   clk, reset (async, active-low)
//   cfg_wr_en/cfg_wr_addr/cfg_wr_data : descriptor ROM write (IDLE only)
//   cfg_num_entries                   : descriptors to walk, sampled on start
//   start/done/busy                   : launch pulse, end pulse, activity flag
//   rd_ready/rd_req                   : request handshake (rd_req implies rd_ready)
//   rd_addr/rd_req_size/rd_type       : registered request attributes
module mem_rd_req_gen #(
  parameter int ADDR_W        = 32,
  parameter int BASE_ADDR_W   = ADDR_W,
  parameter int OFFSET_ADDR_W = ADDR_W,
  parameter int TX_SIZE_WIDTH = 20,
  parameter int RD_LOOP_W     = 10,
  parameter int D_TYPE_W      = 1,
  parameter int ROM_ADDR_W    = 6
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cfg_wr_en,
  input  logic [ROM_ADDR_W-1:0]    cfg_wr_addr,
  input  logic [D_TYPE_W+BASE_ADDR_W+OFFSET_ADDR_W
                +TX_SIZE_WIDTH+RD_LOOP_W-1:0] cfg_wr_data,
  input  logic [ROM_ADDR_W:0]      cfg_num_entries,
  input  logic                     start,
  output logic                     done,
  output logic                     busy,
  input  logic                     rd_ready,
  output logic                     rd_req,
  output logic [ADDR_W-1:0]        rd_addr,
  output logic [TX_SIZE_WIDTH-1:0] rd_req_size,
  output logic [D_TYPE_W-1:0]      rd_type
);

  localparam int ROM_WIDTH = D_TYPE_W + BASE_ADDR_W + OFFSET_ADDR_W
                           + TX_SIZE_WIDTH + RD_LOOP_W;
  localparam int ROM_DEPTH = 1 << ROM_ADDR_W;

  localparam int LOOP_LSB = 0;
  localparam int SIZE_LSB = LOOP_LSB + RD_LOOP_W;
  localparam int OFF_LSB  = SIZE_LSB + TX_SIZE_WIDTH;
  localparam int BASE_LSB = OFF_LSB + OFFSET_ADDR_W;
  localparam int TYPE_LSB = BASE_LSB + BASE_ADDR_W;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [ROM_WIDTH-1:0] rom [ROM_DEPTH];
  logic [ROM_WIDTH-1:0] rom_rd;

  logic [ROM_ADDR_W:0]      n_max_q;
  logic [ROM_ADDR_W:0]      idx_q;
  logic [ROM_ADDR_W:0]      idx_inc;
  logic [RD_LOOP_W-1:0]     count_q;
  logic [ADDR_W-1:0]        offset_acc_q;
  logic [ADDR_W-1:0]        acc_nxt;
  logic [BASE_ADDR_W-1:0]   base_q;
  logic [OFFSET_ADDR_W-1:0] off_q;
  logic [RD_LOOP_W-1:0]     loop_q;

  logic accept;
  logic last;

  // Writes only land in IDLE; a walk never sees a half-updated table.
  always_ff @(posedge clk) begin
    if (cfg_wr_en && state_q == S_IDLE)
      rom[cfg_wr_addr] <= cfg_wr_data;
  end

  assign rom_rd  = rom[idx_q[ROM_ADDR_W-1:0]];
  assign idx_inc = idx_q + (ROM_ADDR_W+1)'(1);
  assign acc_nxt = offset_acc_q + ADDR_W'(off_q);

  assign accept = (state_q == S_ISSUE) && rd_ready;
  assign last   = (count_q == loop_q);

  assign rd_req = accept;
  assign busy   = (state_q != S_IDLE);
  assign done   = (state_q == S_DONE);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (start)
          state_d = (cfg_num_entries == '0) ? S_DONE : S_FETCH;
      end
      S_FETCH: state_d = S_ISSUE;
      S_ISSUE: begin
        if (rd_ready && last)
          state_d = (idx_inc < n_max_q) ? S_FETCH : S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      n_max_q      <= '0;
      idx_q        <= '0;
      count_q      <= '0;
      offset_acc_q <= '0;
      base_q       <= '0;
      off_q        <= '0;
      loop_q       <= '0;
      rd_addr      <= '0;
      rd_req_size  <= '0;
      rd_type      <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            n_max_q <= cfg_num_entries;
            idx_q   <= '0;
          end
        end
        S_FETCH: begin
          base_q       <= rom_rd[BASE_LSB +: BASE_ADDR_W];
          off_q        <= rom_rd[OFF_LSB  +: OFFSET_ADDR_W];
          loop_q       <= rom_rd[LOOP_LSB +: RD_LOOP_W];
          count_q      <= '0;
          offset_acc_q <= '0;
          // Output registers are preloaded so the first request
          // of the descriptor can go out the very next cycle.
          rd_addr      <= ADDR_W'(rom_rd[BASE_LSB +: BASE_ADDR_W]);
          rd_req_size  <= rom_rd[SIZE_LSB +: TX_SIZE_WIDTH];
          rd_type      <= rom_rd[TYPE_LSB +: D_TYPE_W];
        end
        S_ISSUE: begin
          if (accept) begin
            if (last) begin
              idx_q <= idx_inc;
            end else begin
              count_q      <= count_q + RD_LOOP_W'(1);
              offset_acc_q <= acc_nxt;
              rd_addr      <= ADDR_W'(base_q) + acc_nxt;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_rd_req_gen.sv
// Bench for mem_rd_req_gen: scoreboard of expected requests, monitor on
// the falling edge, timing checks relative to the start cycle.
module tb_mem_rd_req_gen;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cfg_wr_en = 1'b0;
  logic [5:0]  cfg_wr_addr = '0;
  logic [94:0] cfg_wr_data = '0;
  logic [6:0]  cfg_num_entries = '0;
  logic        start = 1'b0;
  logic        rd_ready = 1'b1;
  logic        done;
  logic        busy;
  logic        rd_req;
  logic [31:0] rd_addr;
  logic [19:0] rd_req_size;
  logic [0:0]  rd_type;

  mem_rd_req_gen dut (
    .clk(clk),
    .reset(reset),
    .cfg_wr_en(cfg_wr_en),
    .cfg_wr_addr(cfg_wr_addr),
    .cfg_wr_data(cfg_wr_data),
    .cfg_num_entries(cfg_num_entries),
    .start(start),
    .done(done),
    .busy(busy),
    .rd_ready(rd_ready),
    .rd_req(rd_req),
    .rd_addr(rd_addr),
    .rd_req_size(rd_req_size),
    .rd_type(rd_type)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    logic [19:0] size;
    logic [0:0]  typ;
  } exp_t;

  exp_t exp_q[$];
  int   req_cyc[$];
  int   pat[$];
  int   n_chk = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   t0 = 0;
  int   done_cnt = 0;
  int   done_cyc = 0;
  int   nreq = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic rdy_for(input int c);
    if (c >= 2 && c - 2 < pat.size())
      return pat[c-2] != 0;
    return 1'b1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    rd_ready = rdy_for(cyc - t0);
  endtask

  task automatic wr_desc(input int idx, input logic t,
                         input logic [31:0] b, input logic [31:0] o,
                         input logic [19:0] s, input logic [9:0] l);
    cfg_wr_en   = 1'b1;
    cfg_wr_addr = 6'(idx);
    cfg_wr_data = {t, b, o, s, l};
    tick();
    cfg_wr_en = 1'b0;
  endtask

  task automatic push_desc(input logic t, input logic [31:0] b,
                           input logic [31:0] o, input logic [19:0] s,
                           input int l);
    logic [31:0] a;
    for (int i = 0; i <= l; i++) begin
      a = b + o * 32'(i);
      exp_q.push_back('{addr: a, size: s, typ: t});
    end
  endtask

  task automatic launch(input int n);
    cfg_num_entries = 7'(n);
    start    = 1'b1;
    t0       = cyc;
    done_cnt = 0;
    done_cyc = 0;
    nreq     = 0;
    req_cyc.delete();
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int maxc);
    int k;
    k = 0;
    while (done_cnt == 0 && k < maxc) begin
      tick();
      k++;
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      if (rd_req) begin
        chk("req_while_ready", rd_ready, 1);
        nreq++;
        req_cyc.push_back(cyc - t0);
        chk("sb_has_entry", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("rd_addr", rd_addr, e.addr);
          chk("rd_req_size", rd_req_size, e.size);
          chk("rd_type", rd_type, e.typ);
        end
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", rd_req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_addr", rd_addr, 0);
    chk("rst_size", rd_req_size, 0);
    chk("rst_type", rd_type, 0);
    reset = 1'b1;
    tick();

    // single descriptor; start and a ROM write while busy are ignored
    wr_desc(0, 1'b0, 32'h1000, 32'h40, 20'd64, 10'd3);
    push_desc(1'b0, 32'h1000, 32'h40, 20'd64, 3);
    launch(1);
    chk("s1_busy_t1", busy, 1);
    tick();
    tick();
    start       = 1'b1;
    cfg_wr_en   = 1'b1;
    cfg_wr_addr = '0;
    cfg_wr_data = '1;
    tick();
    start     = 1'b0;
    cfg_wr_en = 1'b0;
    wait_done(20);
    repeat (6) tick();
    chk("s1_done_cnt", done_cnt, 1);
    chk("s1_done_lat", done_cyc - t0, 6);
    chk("s1_nreq", nreq, 4);
    if (req_cyc.size() > 0)
      chk("s1_first_lat", req_cyc[0], 2);
    chk("s1_sb_empty", exp_q.size(), 0);
    chk("s1_busy_end", busy, 0);

    // back-pressure; also shows the busy write was dropped
    push_desc(1'b0, 32'h1000, 32'h40, 20'd64, 3);
    pat = '{1, 0, 0, 1, 1, 0, 1};
    launch(1);
    wait_done(30);
    tick();
    pat.delete();
    chk("bp_done_cnt", done_cnt, 1);
    chk("bp_done_lat", done_cyc - t0, 9);
    chk("bp_nreq", nreq, 4);
    if (req_cyc.size() == 4)
      chk("bp_last_cyc", req_cyc[3], 8);
    chk("bp_sb_empty", exp_q.size(), 0);

    // reset mid-walk, then a clean restart
    push_desc(1'b0, 32'h1000, 32'h40, 20'd64, 3);
    launch(1);
    tick();
    tick();
    tick();
    reset = 1'b0;
    #1;
    chk("mr_req", rd_req, 0);
    chk("mr_busy", busy, 0);
    chk("mr_done", done, 0);
    chk("mr_addr", rd_addr, 0);
    chk("mr_size", rd_req_size, 0);
    chk("mr_type", rd_type, 0);
    chk("mr_nreq", nreq, 2);
    exp_q.delete();
    tick();
    reset = 1'b1;
    tick();
    chk("mr_no_done", done_cnt, 0);
    push_desc(1'b0, 32'h1000, 32'h40, 20'd64, 3);
    launch(1);
    wait_done(20);
    tick();
    chk("rs_done_cnt", done_cnt, 1);
    chk("rs_done_lat", done_cyc - t0, 6);
    chk("rs_nreq", nreq, 4);
    chk("rs_sb_empty", exp_q.size(), 0);

    // two descriptors with a fetch bubble between them
    wr_desc(0, 1'b0, 32'h0, 32'h10, 20'd32, 10'd1);
    wr_desc(1, 1'b1, 32'h800, 32'h8, 20'd16, 10'd0);
    push_desc(1'b0, 32'h0, 32'h10, 20'd32, 1);
    push_desc(1'b1, 32'h800, 32'h8, 20'd16, 0);
    launch(2);
    wait_done(20);
    tick();
    chk("s2_done_cnt", done_cnt, 1);
    chk("s2_done_lat", done_cyc - t0, 6);
    chk("s2_nreq", nreq, 3);
    if (req_cyc.size() == 3)
      chk("s2_bubble", req_cyc[2] - req_cyc[1], 2);
    chk("s2_sb_empty", exp_q.size(), 0);

    // zero descriptors
    launch(0);
    wait_done(10);
    tick();
    chk("n0_done_cnt", done_cnt, 1);
    chk("n0_done_lat", done_cyc - t0, 1);
    chk("n0_nreq", nreq, 0);

    // wrap, with the ROM write in the same cycle as start
    push_desc(1'b0, 32'hFFFF_FFF0, 32'h10, 20'd8, 2);
    cfg_wr_en   = 1'b1;
    cfg_wr_addr = '0;
    cfg_wr_data = {1'b0, 32'hFFFF_FFF0, 32'h10, 20'd8, 10'd2};
    launch(1);
    cfg_wr_en = 1'b0;
    wait_done(20);
    tick();
    chk("wr_done_cnt", done_cnt, 1);
    chk("wr_done_lat", done_cyc - t0, 5);
    chk("wr_nreq", nreq, 3);
    chk("wr_sb_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
